// File: rtl/str_cic_interp.sv
// AXI-stream CIC interpolator: N combs at input rate, zero-stuff by R, N integrators at output rate.
// Output is the last integrator scaled by R^(N-1), which gives unity DC gain.
module str_cic_interp #(
    parameter int DW = 24,
    parameter int R  = 4,
    parameter int N  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic signed [DW-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int LR = $clog2(R);
    localparam int IW = DW + N * LR;
    localparam int SH = (N - 1) * LR;
    localparam logic [LR-1:0] LAST_PHASE = LR'(R - 1);

    typedef logic signed [IW-1:0] acc_t;

    acc_t          comb_dly [N];
    acc_t          integ    [N];
    acc_t          comb_out [N+1];
    acc_t          integ_nxt[N];
    acc_t          integ_in;
    acc_t          hold;
    logic          tlast_hold;
    logic [LR-1:0] phase;
    logic          busy;
    logic          accept;
    logic          advance;
    logic          last_phase;

    assign last_phase    = (phase == LAST_PHASE);
    assign advance       = busy & (~m_axis_tvalid | m_axis_tready);
    assign s_axis_tready = rst_n & (~busy | (advance & last_phase));
    assign accept        = s_axis_tvalid & s_axis_tready;

    // NOTE: combinational datapath uses blocking '=' so each stage sees the value computed just above it.
    always_comb begin
        comb_out[0] = {{(IW-DW){s_axis_tdata[DW-1]}}, s_axis_tdata};
        for (int i = 0; i < N; i++) begin
            comb_out[i+1] = comb_out[i] - comb_dly[i];
        end
    end

    // Zero-stuffing: only the first beat of each input sample feeds the integrator chain.
    always_comb begin
        integ_in     = (phase == '0) ? hold : '0;
        integ_nxt[0] = integ[0] + integ_in;
        for (int i = 1; i < N; i++) begin
            integ_nxt[i] = integ[i] + integ_nxt[i-1];
        end
    end

    // NOTE: the comb/integrator arrays are filter state, not storage, so they are reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                comb_dly[i] <= '0;
                integ[i]    <= '0;
            end
            hold          <= '0;
            tlast_hold    <= 1'b0;
            phase         <= '0;
            busy          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    comb_dly[i] <= comb_out[i];
                end
                hold       <= comb_out[N];
                tlast_hold <= s_axis_tlast;
            end

            if (advance) begin
                for (int i = 0; i < N; i++) begin
                    integ[i] <= integ_nxt[i];
                end
                m_axis_tdata  <= DW'(integ_nxt[N-1] >>> SH);
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= tlast_hold & last_phase;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            // A same-cycle accept on the final beat restarts the phase with busy held high.
            if (accept) begin
                busy  <= 1'b1;
                phase <= '0;
            end else if (advance) begin
                phase <= phase + 1'b1;
                if (last_phase) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_str_cic_interp.sv
// Self-checking bench for str_cic_interp: random stimulus compared against a convolution model
// built from the (1 + z^-1 + ... + z^-(R-1))^N impulse response of the interpolator.
module tb_str_cic_interp;

    localparam int DW = 24;
    localparam int R  = 4;
    localparam int N  = 3;
    localparam int HL = N * (R - 1) + 1;
    localparam int SH = (N - 1) * 2;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] s_tdata;
    logic                 s_tvalid;
    logic                 s_tready;
    logic                 s_tlast;
    logic signed [DW-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;

    str_cic_interp #(.DW(DW), .R(R), .N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model state: accepted samples since reset and the output beats seen.
    longint h[HL];
    longint xs[$];
    bit     ls[$];
    longint obs[$];
    int     last_idx[$];
    int     beat_n;
    bit     bp_en;
    bit     prev_stall;
    longint prev_data;
    bit     prev_last;

    function automatic longint model_beat(input int n);
        longint               acc;
        int                   d;
        logic signed [DW-1:0] t;
        acc = 0;
        for (int k = 0; k < xs.size(); k++) begin
            d = n - R * k;
            if (d >= 0 && d < HL) acc += xs[k] * h[d];
        end
        t = DW'(acc >>> SH);
        return longint'(t);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            xs.delete();
            ls.delete();
            obs.delete();
            last_idx.delete();
            beat_n     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, prev_data);
                check("stall_last", m_tlast, prev_last);
            end
            if (m_tvalid && m_tready) begin
                if (beat_n / R >= xs.size()) begin
                    check("extra_beat", beat_n, R * xs.size());
                end else begin
                    check("beat_data", m_tdata, model_beat(beat_n));
                    check("beat_last", m_tlast, (ls[beat_n/R] && (beat_n % R == R - 1)) ? 1 : 0);
                end
                obs.push_back(longint'(m_tdata));
                if (m_tlast) last_idx.push_back(beat_n);
                beat_n++;
            end
            if (s_tvalid && s_tready) begin
                xs.push_back(longint'(s_tdata));
                ls.push_back(s_tlast);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = longint'(m_tdata);
            prev_last  = m_tlast;
        end
    end

    always @(posedge clk) begin
        #1;
        m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic signed [DW-1:0] d, input logic l);
        int w;
        w        = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!s_tready && w < 2000);
        if (!s_tready) check("send_timeout", s_tready, 1);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #2;
            w++;
        end while ((m_tvalid || beat_n < R * xs.size()) && w < 3000);
        repeat (3) @(negedge clk);
        check("drain_count", beat_n, R * xs.size());
    endtask

    task automatic impulse();
        send(24'sd4096, 1'b0);
        repeat (3) send('0, 1'b0);
        drain();
    endtask

    task automatic check_impulse(input string tag);
        longint imp[16];
        imp = '{256, 768, 1536, 2560, 3072, 3072, 2560, 1536, 768, 256, 0, 0, 0, 0, 0, 0};
        check({tag, "_len"}, obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++) check(tag, obs[i], imp[i]);
    endtask

    initial begin
        longint tmp[HL];
        int     gaps;
        int     rdy_hi;
        int     w;

        for (int i = 0; i < HL; i++) h[i] = (i == 0) ? 1 : 0;
        repeat (N) begin
            for (int i = 0; i < HL; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < R; j++) if (i - j >= 0) tmp[i] += h[i-j];
            end
            h = tmp;
        end

        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        bp_en    = 1'b0;
        beat_n   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tready", s_tready, 0);
        rst_n = 1'b1;

        // Impulse response.
        impulse();
        check_impulse("impulse");

        // DC gain at a mid value and at the negative full-scale limit.
        do_reset();
        repeat (8) send(24'sd1000, 1'b0);
        drain();
        for (int i = 10; i < 32 && i < obs.size(); i++) check("dc_pos", obs[i], 1000);
        do_reset();
        repeat (8) send(-24'sd8388608, 1'b0);
        drain();
        for (int i = 10; i < 32 && i < obs.size(); i++) check("dc_neg", obs[i], -8388608);

        // Random backpressure on the impulse.
        do_reset();
        bp_en = 1'b1;
        impulse();
        check_impulse("bp_impulse");
        bp_en = 1'b0;

        // Full throughput with continuous input.
        do_reset();
        gaps   = 0;
        rdy_hi = 0;
        fork
            begin
                repeat (16) send(DW'($urandom), 1'b0);
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!m_tvalid && w < 200);
                check("thru_start", m_tvalid, 1);
                repeat (40) begin
                    if (!m_tvalid) gaps++;
                    if (s_tready) rdy_hi++;
                    @(negedge clk);
                end
            end
        join
        drain();
        check("thru_gaps", gaps, 0);
        check("thru_ready", rdy_hi, 10);

        // tlast on the 4th input lands on output beat 16 only.
        do_reset();
        repeat (3) send(DW'($urandom), 1'b0);
        send(DW'($urandom), 1'b1);
        drain();
        check("tlast_count", last_idx.size(), 1);
        if (last_idx.size() > 0) check("tlast_beat", last_idx[0], 15);

        // Reset during the second beat of an impulse, then a clean impulse.
        do_reset();
        send(24'sd4096, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            #2;
            w++;
        end while (beat_n < 1 && w < 200);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tdata", m_tdata, 0);
        check("midrst_tready", s_tready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        impulse();
        check_impulse("post_rst");

        // Random data, frame markers, input gaps and backpressure together.
        do_reset();
        bp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(DW'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        drain();
        bp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
